// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: CHANNELS producers on the input side, one consumer on
// the output side. The arbiter sits on the slave modport; the driving environment
// uses the master modport.
interface arb_mux_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_sel;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_sel
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_sel
    );
endinterface

// File: rtl/arb_mux.sv
// Registered N-channel merge point. A combinational arbiter (fixed priority or
// round-robin) picks one valid channel; its word is captured in a single output
// register that is refilled whenever it is empty or being drained.
module arb_mux #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned MODE     = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    arb_mux_if.slave bus
);
    localparam int CH = int'(CHANNELS);

    logic [WIDTH-1:0]      r_out_data;
    logic [SEL_W-1:0]      r_out_sel;
    logic                  r_out_valid;
    logic [SEL_W-1:0]      r_rr_ptr;

    logic                  w_load_en;
    logic [2*CHANNELS-1:0] w_req_dbl;
    logic [CHANNELS-1:0]   w_req_rot;
    logic [CHANNELS-1:0]   w_grant;
    logic [SEL_W-1:0]      w_grant_idx;
    logic [WIDTH-1:0]      w_grant_data;
    logic [CHANNELS-1:0]   w_in_ready;
    logic                  w_in_xfer;
    logic [SEL_W-1:0]      w_ptr_next;

    assign w_load_en = !r_out_valid || bus.out_ready;

    // In MODE 0 r_rr_ptr never leaves 0, so the rotated search degenerates to
    // plain lowest-index priority.
    assign w_req_dbl = {bus.in_valid, bus.in_valid} >> r_rr_ptr;
    assign w_req_rot = w_req_dbl[CHANNELS-1:0];

    // First requester in rotated order, mapped back to its absolute channel index.
    always_comb begin
        logic found;
        int   off;
        int   pos;
        found = 1'b0;
        off   = 0;
        for (int j = 0; j < CH; j++) begin
            if (!found && w_req_rot[j]) begin
                found = 1'b1;
                off   = j;
            end
        end
        pos = int'(r_rr_ptr) + off;
        if (pos >= CH) begin
            pos = pos - CH;
        end
        w_grant_idx = SEL_W'(pos);
        w_grant     = '0;
        for (int i = 0; i < CH; i++) begin
            w_grant[i] = found && (i == pos);
        end
    end

    // Data of the granted channel (zero when nothing is granted).
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (w_grant[i]) begin
                w_grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Reset gates in_ready so nothing is accepted during the reset cycle.
    assign w_in_ready = (rst_n && w_load_en) ? w_grant : '0;
    assign w_in_xfer  = |w_in_ready;
    assign w_ptr_next = (w_grant_idx == SEL_W'(CH - 1)) ? '0 : w_grant_idx + 1'b1;

    // Output register and round-robin pointer; reset wins over any transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_in_xfer) begin
            r_out_data  <= w_grant_data;
            r_out_sel   <= w_grant_idx;
            r_out_valid <= 1'b1;
            if (MODE == 1) begin
                r_rr_ptr <= w_ptr_next;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sel   = r_out_sel;
endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: one fixed-priority and one round-robin instance share the same
// stimulus. A cycle model (distance-from-pointer arbitration) is checked on every
// negative edge, and directed literal checks pin the model to hand-computed values.
module tb_arb_mux;
    logic         clk;
    logic         rst_n;
    logic [3:0]   valid;
    logic         ordy;
    logic [127:0] in_flat;

    int n_chk;
    int n_err;

    // Model state per mode (index 0 = fixed priority, 1 = round-robin).
    logic        m_valid [2];
    logic [31:0] m_data  [2];
    int          m_sel   [2];
    int          m_ptr   [2];
    logic        n_valid [2];
    logic [31:0] n_data  [2];
    int          n_sel   [2];
    int          n_ptr   [2];

    localparam logic [127:0] DA = {32'h13, 32'h12, 32'h11, 32'h10};
    localparam logic [127:0] DB = {32'h13, 32'hDEADBEEF, 32'h11, 32'hA5A5A5A5};

    arb_mux_if #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) if0 ();
    arb_mux_if #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) if1 ();

    assign if0.in_data   = in_flat;
    assign if0.in_valid  = valid;
    assign if0.out_ready = ordy;
    assign if1.in_data   = in_flat;
    assign if1.in_valid  = valid;
    assign if1.out_ready = ordy;

    arb_mux #(.WIDTH(32), .CHANNELS(4), .SEL_W(2), .MODE(0)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    arb_mux #(.WIDTH(32), .CHANNELS(4), .SEL_W(2), .MODE(1)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Winner is the requester with the smallest forward distance from ptr; -1 if none.
    function automatic int pick(input logic [3:0] v, input int ptr);
        int best;
        int best_d;
        int d;
        best   = -1;
        best_d = 99;
        for (int i = 0; i < 4; i++) begin
            d = (i - ptr + 4) % 4;
            if (v[i] && d < best_d) begin
                best_d = d;
                best   = i;
            end
        end
        return best;
    endfunction

    task automatic model_cycle(input int m, input logic [3:0] rdy, input logic ov,
                               input logic [31:0] od, input logic [1:0] os);
        int         g;
        logic [3:0] exp_rdy;
        g       = pick(valid, (m == 1) ? m_ptr[m] : 0);
        exp_rdy = 4'b0000;
        if (rst_n && (!m_valid[m] || ordy) && g >= 0) begin
            exp_rdy = 4'(1 << g);
        end
        chk($sformatf("m%0d in_ready", m), 32'(rdy), 32'(exp_rdy));
        chk($sformatf("m%0d out_valid", m), 32'(ov), 32'(m_valid[m]));
        chk($sformatf("m%0d out_data", m), od, m_data[m]);
        chk($sformatf("m%0d out_sel", m), 32'(os), 32'(m_sel[m]));

        n_valid[m] = m_valid[m];
        n_data[m]  = m_data[m];
        n_sel[m]   = m_sel[m];
        n_ptr[m]   = m_ptr[m];
        if (!rst_n) begin
            n_valid[m] = 1'b0;
            n_data[m]  = '0;
            n_sel[m]   = 0;
            n_ptr[m]   = 0;
        end else if (exp_rdy != 4'b0000) begin
            n_valid[m] = 1'b1;
            n_data[m]  = in_flat[g*32 +: 32];
            n_sel[m]   = g;
            if (m == 1) begin
                n_ptr[m] = (g + 1) % 4;
            end
        end else if (ordy) begin
            n_valid[m] = 1'b0;
        end
    endtask

    // Compare process: inputs are stable mid-cycle, outputs are register values.
    always @(negedge clk) begin
        model_cycle(0, if0.in_ready, if0.out_valid, if0.out_data, if0.out_sel);
        model_cycle(1, if1.in_ready, if1.out_valid, if1.out_data, if1.out_sel);
    end

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            m_valid[m] <= n_valid[m];
            m_data[m]  <= n_data[m];
            m_sel[m]   <= n_sel[m];
            m_ptr[m]   <= n_ptr[m];
        end
    end

    // Apply one cycle of stimulus just after the edge, return at mid-cycle.
    task automatic drive(input logic r, input logic [3:0] v, input logic rdy,
                         input logic [127:0] dat);
        @(posedge clk);
        #1;
        rst_n   = r;
        valid   = v;
        ordy    = rdy;
        in_flat = dat;
        @(negedge clk);
    endtask

    int exp_seq [6];

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0;
            m_data[m]  = '0;
            m_sel[m]   = 0;
            m_ptr[m]   = 0;
            n_valid[m] = 1'b0;
            n_data[m]  = '0;
            n_sel[m]   = 0;
            n_ptr[m]   = 0;
        end
        exp_seq = '{0, 1, 2, 3, 0, 1};
        rst_n   = 1'b0;
        valid   = 4'b1111;
        ordy    = 1'b1;
        in_flat = DA;

        // Reset with all channels requesting.
        @(negedge clk);
        drive(1'b0, 4'b1111, 1'b1, DA);
        chk("rst out_valid", 32'(if1.out_valid), 32'h0);
        chk("rst out_data", if1.out_data, 32'h0);
        chk("rst out_sel", 32'(if1.out_sel), 32'h0);
        chk("rst in_ready", 32'(if1.in_ready), 32'h0);
        chk("rst in_ready fp", 32'(if0.in_ready), 32'h0);

        // Single word from channel 2, one-cycle latency.
        drive(1'b1, 4'b0100, 1'b1, DB);
        chk("single in_ready", 32'(if1.in_ready), 32'h4);
        drive(1'b1, 4'b0000, 1'b1, DB);
        chk("single out_valid", 32'(if1.out_valid), 32'h1);
        chk("single out_data", if1.out_data, 32'hDEADBEEF);
        chk("single out_sel", 32'(if1.out_sel), 32'h2);
        drive(1'b1, 4'b0000, 1'b1, DB);
        chk("single drained", 32'(if1.out_valid), 32'h0);

        // Round-robin rotation from a fresh pointer.
        drive(1'b0, 4'b1111, 1'b1, DA);
        drive(1'b1, 4'b1111, 1'b1, DA);
        chk("rr first grant", 32'(if1.in_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 4'b1111, 1'b1, DA);
            chk($sformatf("rr out_sel %0d", k), 32'(if1.out_sel), 32'(exp_seq[k]));
            chk($sformatf("rr out_valid %0d", k), 32'(if1.out_valid), 32'h1);
            chk($sformatf("rr out_data %0d", k), if1.out_data, 32'h10 + 32'(exp_seq[k]));
        end

        // Fixed priority with channels 1 and 3 requesting.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b1010, 1'b1, DA);
            chk($sformatf("fp in_ready %0d", k), 32'(if0.in_ready), 32'h2);
            if (k > 0) begin
                chk($sformatf("fp out_sel %0d", k), 32'(if0.out_sel), 32'h1);
            end
        end

        // Backpressure: load channel 0, stall three cycles, then release.
        drive(1'b1, 4'b0001, 1'b1, DB);
        chk("bp load grant", 32'(if1.in_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'b1111, 1'b0, DB);
            chk($sformatf("bp out_data %0d", k), if1.out_data, 32'hA5A5A5A5);
            chk($sformatf("bp out_sel %0d", k), 32'(if1.out_sel), 32'h0);
            chk($sformatf("bp in_ready %0d", k), 32'(if1.in_ready), 32'h0);
        end
        drive(1'b1, 4'b1111, 1'b1, DB);
        chk("bp resume grant", 32'(if1.in_ready), 32'h2);
        drive(1'b1, 4'b0000, 1'b1, DB);
        chk("bp resume out_sel", 32'(if1.out_sel), 32'h1);
        chk("bp resume out_data", if1.out_data, 32'h11);

        // Reset while a word is held and the pointer sits at 3.
        drive(1'b1, 4'b0100, 1'b1, DB);
        chk("mid load grant", 32'(if1.in_ready), 32'h4);
        drive(1'b1, 4'b1111, 1'b0, DB);
        chk("mid held valid", 32'(if1.out_valid), 32'h1);
        drive(1'b0, 4'b1111, 1'b0, DB);
        chk("mid rst in_ready", 32'(if1.in_ready), 32'h0);
        drive(1'b1, 4'b1111, 1'b1, DB);
        chk("mid discarded", 32'(if1.out_valid), 32'h0);
        chk("mid first grant", 32'(if1.in_ready), 32'h1);
        drive(1'b1, 4'b0000, 1'b1, DB);
        chk("mid out_sel", 32'(if1.out_sel), 32'h0);
        chk("mid out_data", if1.out_data, 32'hA5A5A5A5);

        drive(1'b1, 4'b0000, 1'b1, DB);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
